// File: rtl/axis_hfilter121.sv
// Streaming 1x3 horizontal [1 2 1]/4 smoothing filter on an AXI-Stream pixel
// stream. Rows are delimited by tlast; edge pixels are replicated.
module axis_hfilter121 #(
  parameter int  LANES     = 1,
  parameter int  LANE_BITS = 8,
  localparam int DATA_BITS = LANES * LANE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [DATA_BITS-1:0] axis_s_data_i,
  input  logic                 axis_s_valid_i,
  output logic                 axis_s_ready_o,
  input  logic                 axis_s_last_i,
  output logic [DATA_BITS-1:0] axis_m_data_o,
  output logic                 axis_m_valid_o,
  input  logic                 axis_m_ready_i,
  output logic                 axis_m_last_o
);

  // Handshake: a beat moves on a rising edge where valid && ready are both high;
  // valid never waits on ready, and a presented output beat holds until taken.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAVE  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] prev_q, prev_d;
  logic [DATA_BITS-1:0] cur_q, cur_d;
  logic [DATA_BITS-1:0] m_data_q;
  logic                 m_valid_q;
  logic                 m_last_q;

  logic                 slot_free;
  logic                 s_accept;
  logic                 emit;
  logic [DATA_BITS-1:0] emit_data;
  logic                 emit_last;
  logic [DATA_BITS-1:0] tap_c;
  logic [DATA_BITS-1:0] filt;

  // Each lane sums in LANE_BITS+2 bits so carries stay inside the lane.
  function automatic logic [DATA_BITS-1:0] kern121(
    input logic [DATA_BITS-1:0] a,
    input logic [DATA_BITS-1:0] b,
    input logic [DATA_BITS-1:0] c
  );
    logic [LANE_BITS+1:0] sum;
    kern121 = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = {2'b00, a[l*LANE_BITS +: LANE_BITS]}
          + {1'b0, b[l*LANE_BITS +: LANE_BITS], 1'b0}
          + {2'b00, c[l*LANE_BITS +: LANE_BITS]}
          + (LANE_BITS+2)'(2);
      kern121[l*LANE_BITS +: LANE_BITS] = LANE_BITS'(sum >> 2);
    end
  endfunction

  assign slot_free      = !m_valid_q || axis_m_ready_i;
  assign axis_s_ready_o = rstn_i && slot_free && (state_q != FLUSH);
  assign s_accept       = axis_s_valid_i && axis_s_ready_o;

  // In FLUSH the right neighbour is the row's last pixel itself.
  assign tap_c = (state_q == FLUSH) ? cur_q : axis_s_data_i;
  assign filt  = kern121(prev_q, cur_q, tap_c);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    emit      = 1'b0;
    emit_data = filt;
    emit_last = 1'b0;
    case (state_q)
      EMPTY: begin
        if (s_accept) begin
          if (axis_s_last_i) begin
            // 1-pixel row: f(x,x,x) == x exactly, so pass it straight through.
            emit      = 1'b1;
            emit_data = axis_s_data_i;
            emit_last = 1'b1;
          end else begin
            prev_d  = axis_s_data_i;
            cur_d   = axis_s_data_i;
            state_d = HAVE;
          end
        end
      end
      HAVE: begin
        if (s_accept) begin
          emit   = 1'b1;
          prev_d = cur_q;
          cur_d  = axis_s_data_i;
          if (axis_s_last_i) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit      = 1'b1;
          emit_last = 1'b1;
          state_d   = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= EMPTY;
      prev_q  <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
    end
  end

  // Output register only advances when the slot is free, so data and last
  // stay frozen while the downstream stalls a presented beat.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (slot_free) begin
      m_valid_q <= emit;
      if (emit) begin
        m_data_q <= emit_data;
        m_last_q <= emit_last;
      end
    end
  end

  assign axis_m_data_o  = m_data_q;
  assign axis_m_valid_o = m_valid_q;
  assign axis_m_last_o  = m_last_q;

endmodule

// File: tb/tb_axis_hfilter121.sv
// Bench for axis_hfilter121: cycle-exact vector table on a 1-lane instance,
// plus hand sequences for FLUSH stalls, 3-lane packing and mid-row reset.
module tb_axis_hfilter121;

  logic        clk;
  logic        rstn;

  logic [7:0]  s_data1;
  logic        s_valid1;
  logic        s_ready1;
  logic        s_last1;
  logic [7:0]  m_data1;
  logic        m_valid1;
  logic        m_ready1;
  logic        m_last1;

  logic [23:0] s_data3;
  logic        s_valid3;
  logic        s_ready3;
  logic        s_last3;
  logic [23:0] m_data3;
  logic        m_valid3;
  logic        m_ready3;
  logic        m_last3;

  int checks;
  int errors;

  typedef struct {
    int v;
    int d;
    int l;
    int r;
    int exp_rdy;
    int exp_v;
    int exp_d;
    int exp_l;
  } vec_t;

  vec_t vecs[29];

  axis_hfilter121 #(.LANES(1), .LANE_BITS(8)) dut1 (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .axis_s_data_i  (s_data1),
    .axis_s_valid_i (s_valid1),
    .axis_s_ready_o (s_ready1),
    .axis_s_last_i  (s_last1),
    .axis_m_data_o  (m_data1),
    .axis_m_valid_o (m_valid1),
    .axis_m_ready_i (m_ready1),
    .axis_m_last_o  (m_last1)
  );

  axis_hfilter121 #(.LANES(3), .LANE_BITS(8)) dut3 (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .axis_s_data_i  (s_data3),
    .axis_s_valid_i (s_valid3),
    .axis_s_ready_o (s_ready3),
    .axis_s_last_i  (s_last3),
    .axis_m_data_o  (m_data3),
    .axis_m_valid_o (m_valid3),
    .axis_m_ready_i (m_ready3),
    .axis_m_last_o  (m_last3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int d, input int l, input int r,
                              input int er, input int ev, input int ed, input int el);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.exp_rdy = er; t.exp_v = ev; t.exp_d = ed; t.exp_l = el;
    return t;
  endfunction

  // One cycle on the 1-lane DUT: drive at negedge, check 1 ns later, move on.
  task automatic cyc1(input vec_t t, input string tag);
    s_valid1 = t.v[0];
    s_data1  = t.d[7:0];
    s_last1  = t.l[0];
    m_ready1 = t.r[0];
    #1;
    check({tag, " s_ready"}, int'(s_ready1), t.exp_rdy);
    check({tag, " m_valid"}, int'(m_valid1), t.exp_v);
    if (t.exp_v != 0) begin
      check({tag, " m_data"}, int'(m_data1), t.exp_d);
      check({tag, " m_last"}, int'(m_last1), t.exp_l);
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    s_valid1 = 1'b0; s_data1 = '0; s_last1 = 1'b0; m_ready1 = 1'b1;
    s_valid3 = 1'b0; s_data3 = '0; s_last3 = 1'b0; m_ready3 = 1'b1;

    // row [10,20,30,40] -> [13,20,30,38], one FLUSH bubble
    vecs[0]  = mk(1, 10,  0, 1, 1, 0, 0,   0);
    vecs[1]  = mk(1, 20,  0, 1, 1, 0, 0,   0);
    vecs[2]  = mk(1, 30,  0, 1, 1, 1, 13,  0);
    vecs[3]  = mk(1, 40,  1, 1, 1, 1, 20,  0);
    vecs[4]  = mk(0, 0,   0, 1, 0, 1, 30,  0);
    vecs[5]  = mk(0, 0,   0, 1, 1, 1, 38,  1);
    // 1-pixel rows 200, 7 back-to-back
    vecs[6]  = mk(1, 200, 1, 1, 1, 0, 0,   0);
    vecs[7]  = mk(1, 7,   1, 1, 1, 1, 200, 1);
    // extremes [255,0,255] -> [191,128,191]
    vecs[8]  = mk(1, 255, 0, 1, 1, 1, 7,   1);
    vecs[9]  = mk(1, 0,   0, 1, 1, 0, 0,   0);
    vecs[10] = mk(1, 255, 1, 1, 1, 1, 191, 0);
    vecs[11] = mk(0, 0,   0, 1, 0, 1, 128, 0);
    vecs[12] = mk(0, 0,   0, 1, 1, 1, 191, 1);
    // backpressure, m_ready 1,0,0,1,0,1,1,1 : [0,4,8,12] -> [1,4,8,11]
    vecs[13] = mk(1, 0,   0, 1, 1, 0, 0,   0);
    vecs[14] = mk(1, 4,   0, 0, 1, 0, 0,   0);
    vecs[15] = mk(1, 8,   0, 0, 0, 1, 1,   0);
    vecs[16] = mk(1, 8,   0, 1, 1, 1, 1,   0);
    vecs[17] = mk(1, 12,  1, 0, 0, 1, 4,   0);
    vecs[18] = mk(1, 12,  1, 1, 1, 1, 4,   0);
    vecs[19] = mk(0, 0,   0, 1, 0, 1, 8,   0);
    vecs[20] = mk(0, 0,   0, 1, 1, 1, 11,  1);
    vecs[21] = mk(0, 0,   0, 1, 1, 0, 0,   0);
    // valid gap mid-row: [40, -, -, 80] -> [50,70]
    vecs[22] = mk(1, 40,  0, 1, 1, 0, 0,   0);
    vecs[23] = mk(0, 0,   0, 1, 1, 0, 0,   0);
    vecs[24] = mk(0, 0,   0, 1, 1, 0, 0,   0);
    vecs[25] = mk(1, 80,  1, 1, 1, 0, 0,   0);
    vecs[26] = mk(0, 0,   0, 1, 0, 1, 50,  0);
    vecs[27] = mk(0, 0,   0, 1, 1, 1, 70,  1);
    vecs[28] = mk(0, 0,   0, 1, 1, 0, 0,   0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset s_ready1", int'(s_ready1), 0);
    check("reset m_valid1", int'(m_valid1), 0);
    check("reset m_data1",  int'(m_data1),  0);
    check("reset m_last1",  int'(m_last1),  0);
    check("reset m_valid3", int'(m_valid3), 0);
    check("reset m_data3",  int'(m_data3),  0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 29; i++) begin
      cyc1(vecs[i], $sformatf("vec%0d", i));
    end

    // FLUSH held under backpressure: [100,200] -> [125,175]; offered 33 ignored
    cyc1(mk(1, 100, 0, 1, 1, 0, 0,   0), "fl0");
    cyc1(mk(1, 200, 1, 0, 1, 0, 0,   0), "fl1");
    cyc1(mk(0, 0,   0, 0, 0, 1, 125, 0), "fl2");
    cyc1(mk(1, 33,  1, 0, 0, 1, 125, 0), "fl3");
    cyc1(mk(0, 0,   0, 0, 0, 1, 125, 0), "fl4");
    cyc1(mk(0, 0,   0, 1, 0, 1, 125, 0), "fl5");
    cyc1(mk(0, 0,   0, 1, 1, 1, 175, 1), "fl6");
    cyc1(mk(0, 0,   0, 1, 1, 0, 0,   0), "fl7");

    // 3 lanes {R,G,B}: {255,0,16},{255,255,0} -> {255,64,12},{255,191,4}
    s_valid3 = 1'b1; s_data3 = 24'hFF0010; s_last3 = 1'b0;
    #1;
    check("l3a s_ready", int'(s_ready3), 1);
    check("l3a m_valid", int'(m_valid3), 0);
    @(negedge clk);
    s_valid3 = 1'b1; s_data3 = 24'hFFFF00; s_last3 = 1'b1;
    #1;
    check("l3b s_ready", int'(s_ready3), 1);
    check("l3b m_valid", int'(m_valid3), 0);
    @(negedge clk);
    s_valid3 = 1'b0; s_data3 = '0; s_last3 = 1'b0;
    #1;
    check("l3c s_ready", int'(s_ready3), 0);
    check("l3c m_valid", int'(m_valid3), 1);
    check("l3c m_data",  int'(m_data3),  32'h00FF400C);
    check("l3c m_last",  int'(m_last3),  0);
    @(negedge clk);
    #1;
    check("l3d s_ready", int'(s_ready3), 1);
    check("l3d m_valid", int'(m_valid3), 1);
    check("l3d m_data",  int'(m_data3),  32'h00FFBF04);
    check("l3d m_last",  int'(m_last3),  1);
    @(negedge clk);
    #1;
    check("l3e m_valid", int'(m_valid3), 0);
    @(negedge clk);

    // reset mid-row after [50,60]; then row [9] must come out alone
    cyc1(mk(1, 50, 0, 1, 1, 0, 0, 0), "rs0");
    cyc1(mk(1, 60, 0, 1, 1, 0, 0, 0), "rs1");
    s_valid1 = 1'b1; s_data1 = 8'd70; s_last1 = 1'b0; m_ready1 = 1'b1;
    rstn = 1'b0;
    #1;
    check("rs2 s_ready", int'(s_ready1), 0);
    check("rs2 m_valid", int'(m_valid1), 0);
    check("rs2 m_data",  int'(m_data1),  0);
    check("rs2 m_last",  int'(m_last1),  0);
    @(negedge clk);
    #1;
    check("rs3 s_ready", int'(s_ready1), 0);
    check("rs3 m_valid", int'(m_valid1), 0);
    check("rs3 m_data",  int'(m_data1),  0);
    @(negedge clk);
    rstn = 1'b1;
    cyc1(mk(1, 9, 1, 1, 1, 0, 0, 0), "rs4");
    cyc1(mk(0, 0, 0, 1, 1, 1, 9, 1), "rs5");
    cyc1(mk(0, 0, 0, 1, 1, 0, 0, 0), "rs6");
    cyc1(mk(0, 0, 0, 1, 1, 0, 0, 0), "rs7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
